// File: rtl/int_wb_arbiter.sv
// rtl/int_wb_arbiter.sv - integer writeback arbiter: round-robin grant of NUM_FU units onto NUM_WP lanes
// Optional starvation guard: define WB_ARB_STARVE_GUARD_EN.

package int_wb_pkg;
  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [4:0]  irob_idx;
    logic        use_imm;
    logic        rd_wen;
    logic [5:0]  iprd_idx;
    logic [31:0] result;
  } comwbInfo_t;
endpackage

module int_wb_arbiter
  import int_wb_pkg::*;
#(
  parameter int NUM_FU       = 4,
  parameter int NUM_WP       = 2,
  parameter int STARVE_LIMIT = 7,
  localparam int PTR_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FU-1:0]       i_fu_vld,
  input  comwbInfo_t [NUM_FU-1:0] i_fu_wbInfo,
  output logic [NUM_FU-1:0]       o_fu_wb_stall,
  input  logic                    i_rf_stall,
  output logic [NUM_WP-1:0]       o_wb_vld,
  output comwbInfo_t [NUM_WP-1:0] o_wbInfo,
  output logic [PTR_W-1:0]        o_rr_ptr
);

  if (NUM_WP < 1 || NUM_WP > NUM_FU || STARVE_LIMIT < 1) begin : g_param_check
    $error("int_wb_arbiter: invalid parameter set");
  end

  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_FU-1:0] grant;
  logic [NUM_WP-1:0] lane_vld;
  logic [PTR_W-1:0]  lane_src [NUM_WP];
  logic              last_vld;
  logic [PTR_W-1:0]  last_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic [PTR_W-1:0]  scan_idx;
  int                fill;
  int                scan_sum;
  logic              force_vld;
  logic [PTR_W-1:0]  force_idx;

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt [NUM_FU];

  // Lowest-index unit whose wait counter has saturated jumps the queue.
  always_comb begin
    force_vld = 1'b0;
    force_idx = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (i_fu_vld[i] && (starve_cnt[i] >= CNT_W'(STARVE_LIMIT))) begin
        force_vld = 1'b1;
        force_idx = PTR_W'(i);
      end
    end
  end

  // Per-unit wait counter: counts real (non-rf-stalled) losses, clears on effective grant or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!i_fu_vld[i] || (grant[i] && !i_rf_stall)) begin
          starve_cnt[i] <= '0;
        end else if (!i_rf_stall && o_fu_wb_stall[i] && (starve_cnt[i] < CNT_W'(STARVE_LIMIT))) begin
          starve_cnt[i] <= starve_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Pure round-robin: no forced grant ever.
  always_comb begin
    force_vld = 1'b0;
    force_idx = '0;
  end
`endif

  // Scan from rr_ptr with wrap; first requesters fill lanes in scan order after any forced grant.
  always_comb begin
    grant    = '0;
    lane_vld = '0;
    for (int w = 0; w < NUM_WP; w++) lane_src[w] = '0;
    last_vld = 1'b0;
    last_idx = rr_ptr;
    fill     = 0;
    scan_sum = 0;
    scan_idx = '0;
    if (force_vld) begin
      grant[force_idx] = 1'b1;
      lane_vld[0]      = 1'b1;
      lane_src[0]      = force_idx;
      fill             = 1;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      scan_sum = int'(rr_ptr) + k;
      if (scan_sum >= NUM_FU) scan_sum = scan_sum - NUM_FU;
      scan_idx = PTR_W'(scan_sum);
      if (i_fu_vld[scan_idx] && (fill < NUM_WP) && !(force_vld && (scan_idx == force_idx))) begin
        grant[scan_idx] = 1'b1;
        for (int w = 0; w < NUM_WP; w++) begin
          if (fill == w) begin
            lane_vld[w] = 1'b1;
            lane_src[w] = scan_idx;
          end
        end
        fill     = fill + 1;
        last_vld = 1'b1;
        last_idx = scan_idx;
      end
    end
  end

  // Next start point sits just past the last unit granted by the scan.
  always_comb begin
    next_ptr = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
  end

  // Ungranted requesters and everyone under a downstream stall must hold.
  always_comb begin
    o_fu_wb_stall = {NUM_FU{i_rf_stall}} | (i_fu_vld & ~grant);
  end

  // Writeback lane registers and round-robin pointer; everything holds under rf stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wb_vld <= '0;
      o_wbInfo <= '0;
      rr_ptr   <= '0;
    end else if (!i_rf_stall) begin
      o_wb_vld <= lane_vld;
      for (int w = 0; w < NUM_WP; w++) begin
        if (lane_vld[w]) o_wbInfo[w] <= i_fu_wbInfo[lane_src[w]];
        else             o_wbInfo[w] <= '0;
      end
      if (last_vld) rr_ptr <= next_ptr;
    end
  end

  assign o_rr_ptr = rr_ptr;

`ifndef SYNTHESIS
  for (genvar g = 0; g < NUM_FU; g++) begin : g_proto
    a_hold_vld: assert property (@(posedge clk) disable iff (rst)
      (i_fu_vld[g] && o_fu_wb_stall[g]) |=> i_fu_vld[g]);
  end
`endif

endmodule

// File: doc/int_wb_arbiter.md
Name: int_wb_arbiter

Overview:
- Integer writeback arbiter; the consumer end of the functional-unit writeback interface.
- Collects completed results (comwbInfo_t) from NUM_FU integer functional units (ALU/BRU, MUL, DIV).
- Grants up to NUM_WP results per cycle to the register-file write ports and ROB completion path.
- Back-pressures every ungranted unit through its per-unit wb_stall.

Parameters:
NUM_FU, 4, number of functional-unit writeback sources
NUM_WP, 2, number of register-file write ports / writeback lanes per cycle
STARVE_LIMIT, 7, consecutive stalled cycles before forced priority (optional feature only)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
i_fu_vld  input  NUM_FU  per-unit writeback request valid
i_fu_wbInfo  input  NUM_FU x comwbInfo_t  per-unit writeback payload (rob_idx, irob_idx, use_imm, rd_wen, iprd_idx, result)
o_fu_wb_stall  output  NUM_FU  per-unit stall; unit holds vld and payload while high
i_rf_stall  input  1  downstream (rf/ROB) cannot accept this cycle
o_wb_vld  output  NUM_WP  writeback lane valid
o_wbInfo  output  NUM_WP x comwbInfo_t  writeback lane payload
o_rr_ptr  output  clog2(NUM_FU)  current round-robin start index (debug/verification)

Behaviour:
- Reset: o_wb_vld=0, all o_wbInfo fields 0 (rd_wen=0), rr_ptr=0. o_fu_wb_stall is combinational; it equals the selection result below.
- Selection (combinational, each cycle): scan units in order rr_ptr, rr_ptr+1, ... modulo NUM_FU. Grant the first NUM_WP units with i_fu_vld=1. Grant k goes to lane k, in scan order.
- Stall: o_fu_wb_stall[i] = i_rf_stall | (i_fu_vld[i] & ~grant[i]). Stall is 0 for non-requesting units unless i_rf_stall=1.
- Latency: 1 cycle. On a posedge with i_rf_stall=0, lane k registers its granted payload and o_wb_vld[k]=1. Lanes with no grant register vld=0; their payload is don't-care but rd_wen is forced to 0.
- i_rf_stall=1: output registers and rr_ptr hold. No grant takes effect. All units stalled.
- rr_ptr update (only when i_rf_stall=0 and at least one grant): rr_ptr <= (index of last granted unit + 1) mod NUM_FU. rr_ptr is unchanged when there are no requests.
- Request with rd_wen=0 is still arbitrated and written back, so the ROB marks completion. Lane rd_wen is copied through unchanged.
- Fewer than NUM_WP requests: all are granted with no stall. Upper lanes are invalid.
- Wrap-around: the scan crosses index NUM_FU-1 to 0 seamlessly.
- A unit dropping i_fu_vld while stalled is a protocol error. A concurrency assertion flags it (simulation only).
- Reset mid-operation: in-flight output lanes are discarded (o_wb_vld=0 next cycle). rr_ptr returns to 0.

Optional Feature:
- Macro WB_ARB_STARVE_GUARD_EN.
- Defined:
  - Each unit has a saturating counter. It increments on each cycle with i_fu_vld & o_fu_wb_stall & ~i_rf_stall, and clears on grant or when not valid.
  - When a counter reaches STARVE_LIMIT, that unit is granted lane 0 ahead of round-robin order. The remaining lanes fill by normal scan, skipping that unit.
  - If several units are starved, the lowest index wins.
  - rr_ptr update ignores the forced grant unless it was also the last scan grant.
- Undefined: no counters; pure round-robin as above.

Test Plan:
- NUM_FU=4, NUM_WP=2, reset, all idle -> o_wb_vld=00, o_fu_wb_stall=0000, rr_ptr=0.
- rr_ptr=0, vld=0111 for one cycle -> units 0,1 granted, unit 2 stalled. Next cycle lane0=FU0 payload, lane1=FU1 payload; rr_ptr=2. Unit 2 held, then granted on lane0.
- vld=1111 held continuously -> grant pairs {0,1},{2,3},{0,1}...; each unit writes back every 2 cycles; rr_ptr toggles 0→2→0.
- rr_ptr=3, vld=1001 -> grants 3 (lane0) and 0 (lane1), no stall; rr_ptr=1.
- i_rf_stall=1 for 3 cycles with vld=0011 -> all stalls=1, outputs hold prior values, rr_ptr unchanged. The cycle after release grants FU0, FU1.
- FU2 rd_wen=0, result=0xDEAD, alone valid -> lane0 vld=1, rd_wen=0, rob_idx matches input. With WB_ARB_STARVE_GUARD_EN and STARVE_LIMIT=2, a unit starved 2 cycles is granted lane0 on the 3rd.
